simd_mult_pair_issuer: RTL and testbench
========================================

SIMD_MULT_PAIR_ISSUER -- requirements
Module: simd_mult_pair_issuer

Interface
REQ-001 SHALL have parameter LATENCY, default 1: cycles from issue_o to lane results valid on z0_i/z1_i, legal range 1..4.
REQ-002 SHALL have parameter DEPTH, default 8: result FIFO entries, power of two, minimum 4.
REQ-003 SHALL have parameter TIMEOUT, default 4: max cycles a lone operand is held before single issue, minimum 1.
REQ-004 SHALL have ports, one per line:
  clock_i  in  1  single clock, all state on rising edge
  reset_i  in  1  asynchronous, active-high reset
  in_valid_i  in  1  request valid
  in_ready_o  out  1  request accepted when valid and ready both high
  in_a_i  in  8  unsigned operand A
  in_b_i  in  8  unsigned operand B
  flush_i  in  1  force issue of a held lone operand
  issue_o  out  1  one-cycle pulse, lane operands valid
  pair_o  out  1  lane 1 carries a real request
  a0_o, b0_o  out  8 each  lane 0 operands to dual-lane DSP
  a1_o, b1_o  out  8 each  lane 1 operands to dual-lane DSP
  z0_i, z1_i  in  16 each  lane products from DSP
  out_valid_o  out  1  result valid
  out_ready_i  in  1  result consumed when valid and ready both high
  out_z_o  out  16  result, in request acceptance order

Function
REQ-005 SHALL pair consecutive accepted requests onto lane 0 (older) and lane 1 (newer) of one DSP issue.
REQ-006 SHALL implement states EMPTY (no held operand) and HALF (one operand held for lane 0).
REQ-007 EMPTY + accept -> HALF, operand latched, hold timer cleared to 0; no issue.
REQ-008 HALF + accept -> next edge: issue_o=1, pair_o=1, a0/b0=held, a1/b1=new, state EMPTY.
REQ-009 HALF, no accept, flush_i=1 or timer==TIMEOUT-1 -> next edge: issue_o=1, pair_o=0, a1_o=b1_o=0, state EMPTY.
REQ-010 HALF, no accept, no flush, timer<TIMEOUT-1 -> timer+1, stay HALF.
REQ-011 Accept and flush_i in same HALF cycle -> pair issue per REQ-008; flush_i in EMPTY SHALL be ignored.
REQ-012 issue_o SHALL be high exactly one cycle per issue; lane operand outputs SHALL hold last issued values between issues.
REQ-013 SHALL carry (issue, pair) through a LATENCY-stage shift register aligned with issue_o; when the tap is set, z0_i SHALL be written to FIFO, then z1_i in the same cycle if pair was set (two writes/cycle).
REQ-014 SHALL keep a reservation counter: +1 per accept, -1 per FIFO entry written; in_ready_o = (reserved + fifo_count) < DEPTH, so FIFO SHALL never overflow.
REQ-015 Simultaneous accept, FIFO write(s) and FIFO read in one cycle SHALL update counters by net sum.
REQ-016 out_valid_o = FIFO non-empty; out_z_o = head entry; head SHALL advance one entry per handshake; out_z_o stable while out_valid_o high and out_ready_i low.
REQ-017 Pointers SHALL wrap modulo DEPTH; full and empty distinguished by count, not pointer equality.
REQ-018 SHALL perform no arithmetic on products; z passed unchanged, 16-bit unsigned.

Reset
REQ-019 reset_i high SHALL immediately force: state EMPTY, timer 0, issue_o=0, pair_o=0, all lane operands 0, shift register cleared, FIFO empty, reserved=0, out_valid_o=0, out_z_o=0, in_ready_o=0.
REQ-020 Reset mid-operation SHALL discard held operand, in-flight results and FIFO contents; in_ready_o SHALL be 1 first cycle after reset_i falls.

Verification (bench DSP model: z = a*b registered LATENCY cycles)
REQ-021 Two back-to-back requests (3,5),(7,9), out_ready_i=1 -> one issue_o, pair_o=1; outputs 15 then 63 on consecutive cycles.
REQ-022 Single request (200,255), then idle, TIMEOUT=4 -> single issue 4 cycles after acceptance, pair_o=0, a1_o=b1_o=0; output 51000.
REQ-023 Single request (12,12), flush_i pulse next cycle -> issue next edge, pair_o=0; output 144; flush_i in EMPTY -> no issue_o.
REQ-024 out_ready_i=0, 10 continuous requests, DEPTH=8 -> in_ready_o drops after 8 accepted; no loss; release -> 8 results in order, then remaining 2.
REQ-025 Accept coinciding with timer==TIMEOUT-1 -> pair issue, no single issue.
REQ-026 reset_i asserted with 1 held operand and 2 results in flight -> all outputs 0 immediately; no stale out_valid_o after release.

Source files
------------

// File: rtl/simd_mult_pair_issuer.sv
// Pairs consecutive 8x8 multiply requests onto the two lanes of a dual-lane DSP.
// Products return through a LATENCY-aligned tag pipe into an in-order result FIFO.
module simd_mult_pair_issuer #(
    parameter int LATENCY = 1,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 4
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [7:0]  in_a_i,
    input  logic [7:0]  in_b_i,
    input  logic        flush_i,
    output logic        issue_o,
    output logic        pair_o,
    output logic [7:0]  a0_o,
    output logic [7:0]  b0_o,
    output logic [7:0]  a1_o,
    output logic [7:0]  b1_o,
    input  logic [15:0] z0_i,
    input  logic [15:0] z1_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [15:0] out_z_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT) + 1;

    typedef enum logic {ST_EMPTY, ST_HALF} state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [7:0]      hold_a_q, hold_a_d, hold_b_q, hold_b_d;
    logic            issue_q, issue_d, pair_q, pair_d;
    logic [7:0]      a0_q, a0_d, b0_q, b0_d, a1_q, a1_d, b1_q, b1_d;
    logic [LATENCY-1:0] sr_issue_q, sr_issue_d, sr_pair_q, sr_pair_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d, reserved_q, reserved_d;
    logic [15:0]     mem_q [DEPTH];

    logic            accept, wr0, wr1, rd;
    logic [CW-1:0]   n_wr;
    logic [CW:0]     occupancy;

    // Every accepted request owns a FIFO slot from acceptance until its product lands.
    assign occupancy  = {1'b0, reserved_q} + {1'b0, count_q};
    assign in_ready_o = !reset_i && (occupancy < (CW+1)'(DEPTH));
    assign accept     = in_valid_i && in_ready_o;

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        hold_a_d = hold_a_q;
        hold_b_d = hold_b_q;
        issue_d  = 1'b0;
        pair_d   = pair_q;
        a0_d     = a0_q;
        b0_d     = b0_q;
        a1_d     = a1_q;
        b1_d     = b1_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d  = ST_HALF;
                    timer_d  = '0;
                    hold_a_d = in_a_i;
                    hold_b_d = in_b_i;
                end
            end
            ST_HALF: begin
                if (accept) begin
                    state_d = ST_EMPTY;
                    issue_d = 1'b1;
                    pair_d  = 1'b1;
                    a0_d    = hold_a_q;
                    b0_d    = hold_b_q;
                    a1_d    = in_a_i;
                    b1_d    = in_b_i;
                end else if (flush_i || timer_q == TW'(TIMEOUT - 1)) begin
                    state_d = ST_EMPTY;
                    issue_d = 1'b1;
                    pair_d  = 1'b0;
                    a0_d    = hold_a_q;
                    b0_d    = hold_b_q;
                    a1_d    = '0;
                    b1_d    = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Tag pipe: stage 0 follows issue_o by one cycle, so the last stage lines up with z*_i.
    assign sr_issue_d[0] = issue_q;
    assign sr_pair_d[0]  = pair_q;
    for (genvar gi = 1; gi < LATENCY; gi++) begin : g_tag_pipe
        assign sr_issue_d[gi] = sr_issue_q[gi-1];
        assign sr_pair_d[gi]  = sr_pair_q[gi-1];
    end

    always_comb begin
        wr0        = sr_issue_q[LATENCY-1];
        wr1        = sr_issue_q[LATENCY-1] && sr_pair_q[LATENCY-1];
        rd         = out_valid_o && out_ready_i;
        n_wr       = CW'(wr0) + CW'(wr1);
        count_d    = count_q + n_wr - CW'(rd);
        reserved_d = reserved_q + CW'(accept) - n_wr;
        wr_ptr_d   = wr_ptr_q + AW'(n_wr);
        rd_ptr_d   = rd_ptr_q + AW'(rd);
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= ST_EMPTY;
            timer_q    <= '0;
            hold_a_q   <= '0;
            hold_b_q   <= '0;
            issue_q    <= 1'b0;
            pair_q     <= 1'b0;
            a0_q       <= '0;
            b0_q       <= '0;
            a1_q       <= '0;
            b1_q       <= '0;
            sr_issue_q <= '0;
            sr_pair_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            reserved_q <= '0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            hold_a_q   <= hold_a_d;
            hold_b_q   <= hold_b_d;
            issue_q    <= issue_d;
            pair_q     <= pair_d;
            a0_q       <= a0_d;
            b0_q       <= b0_d;
            a1_q       <= a1_d;
            b1_q       <= b1_d;
            sr_issue_q <= sr_issue_d;
            sr_pair_q  <= sr_pair_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            reserved_q <= reserved_d;
        end
    end

    // Lane 0 is older, so it takes the lower slot when both lanes land together.
    always_ff @(posedge clock_i) begin
        if (wr0) mem_q[wr_ptr_q] <= z0_i;
        if (wr1) mem_q[wr_ptr_q + AW'(1)] <= z1_i;
    end

    assign issue_o     = issue_q;
    assign pair_o      = pair_q;
    assign a0_o        = a0_q;
    assign b0_o        = b0_q;
    assign a1_o        = a1_q;
    assign b1_o        = b1_q;
    assign out_valid_o = (count_q != '0);
    assign out_z_o     = out_valid_o ? mem_q[rd_ptr_q] : 16'd0;
endmodule

// File: tb/tb_simd_mult_pair_issuer.sv
// Directed and short random stimulus for simd_mult_pair_issuer with a DSP model
// and a scoreboard of expected products in acceptance order.
module tb_simd_mult_pair_issuer;
    localparam int LAT = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, flush, issue, pair;
    logic [7:0]  in_a, in_b, a0, b0, a1, b1;
    logic [15:0] z0, z1, out_z;
    logic        out_valid, out_ready;

    int checks = 0;
    int errors = 0;
    int issue_cnt = 0;
    int in_cnt = 0;
    int out_cnt = 0;
    logic [15:0] exp_q [$];

    simd_mult_pair_issuer #(.LATENCY(LAT), .DEPTH(8), .TIMEOUT(4)) dut (
        .clock_i(clk), .reset_i(rst),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_a_i(in_a), .in_b_i(in_b), .flush_i(flush),
        .issue_o(issue), .pair_o(pair),
        .a0_o(a0), .b0_o(b0), .a1_o(a1), .b1_o(b1),
        .z0_i(z0), .z1_i(z1),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_z_o(out_z)
    );

    always #5 clk = ~clk;

    // DSP model: product of lane operands, registered LAT cycles.
    logic [15:0] p0 [LAT];
    logic [15:0] p1 [LAT];
    always @(posedge clk) begin
        p0[0] <= {8'd0, a0} * {8'd0, b0};
        p1[0] <= {8'd0, a1} * {8'd0, b1};
        for (int s = 1; s < LAT; s++) begin
            p0[s] <= p0[s-1];
            p1[s] <= p1[s-1];
        end
    end
    assign z0 = p0[LAT-1];
    assign z1 = p1[LAT-1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Monitor samples on the falling edge; stimulus changes just after the rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            logic [15:0] prod, head;
            if (issue) issue_cnt++;
            if (in_valid && in_ready) begin
                prod = {8'd0, in_a} * {8'd0, in_b};
                exp_q.push_back(prod);
                in_cnt++;
            end
            if (out_valid && out_ready) begin
                out_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL sb_underflow observed %0d expected no output", out_z);
                end else begin
                    head = exp_q.pop_front();
                    check("sb_order", 32'(out_z), 32'(head));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int c = 0; c < 60 && (exp_q.size() != 0 || out_valid); c++) tick();
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_i, base_o, base_in, sent;
        logic acc;
        rst = 1'b1; in_valid = 0; in_a = 0; in_b = 0; flush = 0; out_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_issue", issue, 0);
        check("rst_pair", pair, 0);
        check("rst_lanes", {a0, b0, a1, b1}, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_z", out_z, 0);
        check("rst_in_ready", in_ready, 0);
        rst = 1'b0;
        #1;
        check("in_ready_after_rst", in_ready, 1);
        tick();

        // Back-to-back pair (3,5),(7,9)
        base_i = issue_cnt;
        in_valid = 1; in_a = 3; in_b = 5;
        tick();
        check("pair_no_early_issue", issue, 0);
        in_a = 7; in_b = 9;
        tick();
        in_valid = 0;
        check("pair_issue", issue, 1);
        check("pair_flag", pair, 1);
        check("pair_lanes", {a0, b0, a1, b1}, {8'd3, 8'd5, 8'd7, 8'd9});
        tick();
        check("pair_issue_pulse", issue, 0);
        check("pair_lanes_held", {a0, b0, a1, b1}, {8'd3, 8'd5, 8'd7, 8'd9});
        tick();
        check("pair_out0_valid", out_valid, 1);
        check("pair_out0", out_z, 15);
        tick();
        check("pair_out1_valid", out_valid, 1);
        check("pair_out1", out_z, 63);
        tick();
        check("pair_out_done", out_valid, 0);
        check("pair_issue_count", issue_cnt - base_i, 1);

        // Lone operand times out
        in_valid = 1; in_a = 200; in_b = 255;
        tick();
        in_valid = 0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check("timeout_early", issue, 0);
        end
        tick();
        check("timeout_issue", issue, 1);
        check("timeout_pair", pair, 0);
        check("timeout_lanes", {a0, b0, a1, b1}, {8'd200, 8'd255, 16'd0});
        drain();

        // Flush of a lone operand, then flush while empty
        in_valid = 1; in_a = 12; in_b = 12;
        tick();
        in_valid = 0; flush = 1;
        tick();
        flush = 0;
        check("flush_issue", issue, 1);
        check("flush_pair", pair, 0);
        drain();
        base_i = issue_cnt;
        flush = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("flush_empty_no_issue", issue, 0);
        end
        flush = 0;
        tick();
        check("flush_empty_count", issue_cnt - base_i, 0);

        // Accept exactly when the timer would expire
        in_valid = 1; in_a = 4; in_b = 6;
        tick();
        in_valid = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("race_no_early_issue", issue, 0);
        end
        in_valid = 1; in_a = 5; in_b = 11;
        tick();
        in_valid = 0;
        check("race_issue", issue, 1);
        check("race_pair", pair, 1);
        check("race_lanes", {a0, b0, a1, b1}, {8'd4, 8'd6, 8'd5, 8'd11});
        tick();
        check("race_single_pulse", issue, 0);
        drain();

        // Backpressure: 10 requests into an 8-deep result path
        base_o = out_cnt;
        out_ready = 0;
        in_valid = 1;
        for (int i = 0; i < 8; i++) begin
            in_a = 8'(i + 1); in_b = 8'(i + 3);
            check("fill_ready", in_ready, 1);
            tick();
        end
        in_a = 9; in_b = 11;
        for (int k = 0; k < 6; k++) begin
            check("full_not_ready", in_ready, 0);
            tick();
        end
        check("full_out_valid", out_valid, 1);
        check("full_head_stable", out_z, 3);
        out_ready = 1;
        sent = 8;
        for (int c = 0; c < 40 && sent < 10; c++) begin
            acc = in_ready;
            tick();
            if (acc) begin
                sent++;
                in_a = 8'(sent + 1); in_b = 8'(sent + 3);
            end
        end
        in_valid = 0;
        check("fill_all_accepted", sent, 10);
        drain();
        check("fill_out_count", out_cnt - base_o, 10);

        // Random mix with backpressure and occasional flush
        base_o = out_cnt;
        base_in = in_cnt;
        for (int c = 0; c < 300; c++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            in_a      = 8'($urandom);
            in_b      = 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 9) == 0);
            tick();
        end
        in_valid = 0; flush = 0; out_ready = 1;
        for (int c = 0; c < 10; c++) tick();
        drain();
        check("rand_in_out_count", out_cnt - base_o, in_cnt - base_in);

        // Reset with a held operand and a pair in flight
        in_valid = 1; in_a = 2; in_b = 3;
        tick();
        in_a = 4; in_b = 5;
        tick();
        in_a = 6; in_b = 7;
        tick();
        in_valid = 0;
        rst = 1'b1;
        #1;
        check("midrst_issue", issue, 0);
        check("midrst_pair", pair, 0);
        check("midrst_lanes", {a0, b0, a1, b1}, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_z", out_z, 0);
        check("midrst_in_ready", in_ready, 0);
        exp_q.delete();
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("midrst_ready_after", in_ready, 1);
        for (int k = 0; k < 10; k++) begin
            tick();
            check("midrst_no_stale_valid", out_valid, 0);
            check("midrst_no_stale_issue", issue, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
